// File: rtl/tw_buf_multistage.sv
// -----------------------------------------------------------------------------
// tw_buf_multistage
//
// Twiddle-factor buffer for the radix-16 NTT/FFT butterfly. It holds
// STAGES x GROUPS x ENTRIES twiddle words. Every stage's table can be
// rewritten at runtime, one half-word per beat. The buffer streams one
// twiddle per cycle, with its own index/sweep/group sequencing, and also
// provides a per-stage constant word.
//
// Ports
//   CLK            rising-edge clock
//   rst_n          asynchronous active-low reset
//   CEN            read enable, active-low
//   stage_counter  current NTT stage; values >= STAGES select the identity
//   adv_en         sequencing qualifier (butterfly compute state)
//   load_valid     load beat strobe
//   load_half      0: write the high half, 1: write the low half
//   load_stage     target stage of a load beat / constant write
//   load_data      half-word to write
//   const_we       constant register write strobe (stage = load_stage)
//   const_data     constant value
//   Q              registered twiddle output (1-cycle latency)
//   Q_valid        Q carries a table entry rather than the identity
//   Q_const        registered per-stage constant
//   grp_idx        current group of the active stage
// -----------------------------------------------------------------------------
module tw_buf_multistage #(
    parameter int P_WIDTH      = 128,
    parameter int STAGES       = 3,
    parameter int GROUPS       = 4,
    parameter int ENTRIES      = 4,
    parameter int GROUP_PERIOD = 16,
    parameter int SC_WIDTH     = 3,
    parameter logic [P_WIDTH-1:0] IDENTITY =
        {{(P_WIDTH/2-1){1'b0}}, 1'b1, {(P_WIDTH/2-1){1'b0}}, 1'b1}
) (
    input  logic                                          CLK,
    input  logic                                          rst_n,
    input  logic                                          CEN,
    input  logic [SC_WIDTH-1:0]                           stage_counter,
    input  logic                                          adv_en,
    input  logic                                          load_valid,
    input  logic                                          load_half,
    input  logic [SC_WIDTH-1:0]                           load_stage,
    input  logic [P_WIDTH/2-1:0]                          load_data,
    input  logic                                          const_we,
    input  logic [P_WIDTH-1:0]                            const_data,
    output logic [P_WIDTH-1:0]                            Q,
    output logic                                          Q_valid,
    output logic [P_WIDTH-1:0]                            Q_const,
    output logic [((GROUPS > 1) ? $clog2(GROUPS) : 1)-1:0] grp_idx
);

    localparam int HALF = P_WIDTH / 2;
    localparam int SW   = (STAGES > 1)       ? $clog2(STAGES)       : 1;
    localparam int GW   = (GROUPS > 1)       ? $clog2(GROUPS)       : 1;
    localparam int EW   = (ENTRIES > 1)      ? $clog2(ENTRIES)      : 1;
    localparam int CW   = (GROUP_PERIOD > 1) ? $clog2(GROUP_PERIOD) : 1;
    localparam int PW   = GW + EW;

    localparam logic [EW-1:0]       IDX_LAST = EW'(ENTRIES - 1);
    localparam logic [CW-1:0]       SWP_LAST = CW'(GROUP_PERIOD - 1);
    localparam logic [GW-1:0]       GRP_LAST = GW'(GROUPS - 1);
    localparam logic [PW-1:0]       PTR_LAST = PW'(GROUPS * ENTRIES - 1);
    // One extra bit so STAGES == 2**SC_WIDTH still compares correctly.
    localparam logic [SC_WIDTH:0]   STAGES_C = (SC_WIDTH + 1)'(STAGES);

    // True when a stage number addresses an existing table.
    function automatic logic stage_ok(input logic [SC_WIDTH-1:0] s);
        return ({1'b0, s} < STAGES_C);
    endfunction

    // Table storage and constant registers
    logic [P_WIDTH-1:0] mem_q   [STAGES][GROUPS][ENTRIES];
    logic [P_WIDTH-1:0] mem_d   [STAGES][GROUPS][ENTRIES];
    logic [P_WIDTH-1:0] const_q [STAGES];
    logic [P_WIDTH-1:0] const_d [STAGES];

    // Sequencer and load pointer
    logic [EW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       sweep_q, sweep_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [SC_WIDTH-1:0] stage_prev_q, stage_prev_d;

    // Output registers
    logic [P_WIDTH-1:0] q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [P_WIDTH-1:0] q_const_q, q_const_d;

    logic          rd_ok;
    logic [SW-1:0] rd_stage;
    logic          ld_ok;
    logic [SW-1:0] ld_stage;
    logic [GW-1:0] ld_grp;
    logic [EW-1:0] ld_ent;

    // ---- read stage: table lookup with the current (pre-update) counters ----
    always_comb begin
        rd_ok     = !CEN && stage_ok(stage_counter);
        rd_stage  = stage_counter[SW-1:0];
        q_d       = IDENTITY;
        q_valid_d = 1'b0;
        q_const_d = q_const_q;
        if (rd_ok) begin
            // mem_q is the pre-write content, so a colliding load is seen next read.
            q_d       = mem_q[rd_stage][grp_q][idx_q];
            q_valid_d = 1'b1;
            q_const_d = const_q[rd_stage];
        end
    end

    // ---- sequencer: idx sweeps entries, sweep counts passes, grp steps groups ----
    always_comb begin
        idx_d        = idx_q;
        sweep_d      = sweep_q;
        grp_d        = grp_q;
        stage_prev_d = stage_counter;
        if (stage_counter != stage_prev_q) begin
            // A stage switch restarts the sequence regardless of CEN/adv_en.
            idx_d   = '0;
            sweep_d = '0;
            grp_d   = '0;
        end else if (!CEN) begin
            if (adv_en) begin
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (sweep_q == SWP_LAST) begin
                        sweep_d = '0;
                        grp_d   = (grp_q == GRP_LAST) ? '0 : grp_q + 1'b1;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                // Leaving the compute state restarts the sweep within the same group.
                idx_d   = '0;
                sweep_d = '0;
            end
        end
    end

    // ---- load stage: half-word table writes and constant writes ----
    always_comb begin
        mem_d    = mem_q;
        const_d  = const_q;
        ptr_d    = '0;
        ld_ok    = stage_ok(load_stage);
        ld_stage = load_stage[SW-1:0];
        ld_grp   = ptr_q[PW-1:EW];
        ld_ent   = ptr_q[EW-1:0];
        if (load_valid) begin
            if (ld_ok) begin
                if (load_half) begin
                    mem_d[ld_stage][ld_grp][ld_ent][HALF-1:0] = load_data;
                end else begin
                    mem_d[ld_stage][ld_grp][ld_ent][P_WIDTH-1:HALF] = load_data;
                end
            end
            // Out-of-range beats still consume an address so bursts stay aligned.
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
        if (const_we && ld_ok) begin
            const_d[ld_stage] = const_data;
        end
    end

    // ---- storage registers ----
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                const_q[s] <= IDENTITY;
                for (int g = 0; g < GROUPS; g++) begin
                    for (int e = 0; e < ENTRIES; e++) begin
                        mem_q[s][g][e] <= IDENTITY;
                    end
                end
            end
        end else begin
            mem_q   <= mem_d;
            const_q <= const_d;
        end
    end

    // ---- control and output registers ----
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            sweep_q      <= '0;
            grp_q        <= '0;
            ptr_q        <= '0;
            stage_prev_q <= '0;
            q_q          <= IDENTITY;
            q_valid_q    <= 1'b0;
            q_const_q    <= IDENTITY;
        end else begin
            idx_q        <= idx_d;
            sweep_q      <= sweep_d;
            grp_q        <= grp_d;
            ptr_q        <= ptr_d;
            stage_prev_q <= stage_prev_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            q_const_q    <= q_const_d;
        end
    end

    assign Q       = q_q;
    assign Q_valid = q_valid_q;
    assign Q_const = q_const_q;
    assign grp_idx = grp_q;

endmodule

// File: tb/tb_tw_buf_multistage.sv
module tb_tw_buf_multistage;

    localparam int P_WIDTH      = 128;
    localparam int STAGES       = 3;
    localparam int GROUPS       = 4;
    localparam int ENTRIES      = 4;
    localparam int GROUP_PERIOD = 16;
    localparam int SC_WIDTH     = 3;
    localparam logic [127:0] ID = {64'd1, 64'd1};

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         CEN = 1'b1;
    logic [2:0]   stage_counter = 3'd0;
    logic         adv_en = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_half = 1'b0;
    logic [2:0]   load_stage = 3'd0;
    logic [63:0]  load_data = 64'd0;
    logic         const_we = 1'b0;
    logic [127:0] const_data = 128'd0;
    logic [127:0] Q;
    logic         Q_valid;
    logic [127:0] Q_const;
    logic [1:0]   grp_idx;

    tw_buf_multistage #(
        .P_WIDTH(P_WIDTH), .STAGES(STAGES), .GROUPS(GROUPS), .ENTRIES(ENTRIES),
        .GROUP_PERIOD(GROUP_PERIOD), .SC_WIDTH(SC_WIDTH)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .CEN(CEN), .stage_counter(stage_counter),
        .adv_en(adv_en), .load_valid(load_valid), .load_half(load_half),
        .load_stage(load_stage), .load_data(load_data), .const_we(const_we),
        .const_data(const_data), .Q(Q), .Q_valid(Q_valid), .Q_const(Q_const),
        .grp_idx(grp_idx)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: tables as plain arrays, sequencing as a position
    // inside the current group (advances since the group started).
    logic [127:0] m_mem   [STAGES][GROUPS][ENTRIES];
    logic [127:0] m_const [STAGES];
    int           m_pos;
    int           m_grp;
    int           m_ptr;
    logic [2:0]   m_prev;
    logic [127:0] e_q;
    logic         e_v;
    logic [127:0] e_qc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"}, Q, e_q);
        chk({tag, ".Q_valid"}, 128'(Q_valid), 128'(e_v));
        chk({tag, ".Q_const"}, Q_const, e_qc);
        chk({tag, ".grp_idx"}, 128'(grp_idx), 128'(m_grp));
    endtask

    task automatic m_reset();
        for (int s = 0; s < STAGES; s++) begin
            m_const[s] = ID;
            for (int g = 0; g < GROUPS; g++)
                for (int e = 0; e < ENTRIES; e++)
                    m_mem[s][g][e] = ID;
        end
        m_pos = 0; m_grp = 0; m_ptr = 0; m_prev = 3'd0;
        e_q = ID; e_v = 1'b0; e_qc = ID;
    endtask

    // One clock cycle: predict from the current inputs, clock, then compare.
    task automatic step(input string tag);
        int s, ls, g, e;
        s  = int'(stage_counter);
        ls = int'(load_stage);
        if (!CEN && s < STAGES) begin
            e_q  = m_mem[s][m_grp][m_pos % ENTRIES];
            e_v  = 1'b1;
            e_qc = m_const[s];
        end else begin
            e_q = ID;
            e_v = 1'b0;
        end
        if (stage_counter != m_prev) begin
            m_pos = 0;
            m_grp = 0;
        end else if (!CEN) begin
            if (adv_en) begin
                m_pos++;
                if (m_pos == ENTRIES * GROUP_PERIOD) begin
                    m_pos = 0;
                    m_grp = (m_grp + 1) % GROUPS;
                end
            end else begin
                m_pos = 0;
            end
        end
        m_prev = stage_counter;
        if (load_valid) begin
            if (ls < STAGES) begin
                g = m_ptr / ENTRIES;
                e = m_ptr % ENTRIES;
                if (load_half) m_mem[ls][g][e][63:0]   = load_data;
                else           m_mem[ls][g][e][127:64] = load_data;
            end
            m_ptr = (m_ptr + 1) % (GROUPS * ENTRIES);
        end else begin
            m_ptr = 0;
        end
        if (const_we && ls < STAGES) m_const[ls] = const_data;
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(posedge CLK);
        #1 rst_n = 1'b1;
        check_all("rst_hold");
    endtask

    // 16 beats of one half into load_stage st, then a 1-cycle gap.
    task automatic load_burst(input logic [2:0] st, input logic half,
                              input logic [63:0] base, input bit rnd);
        for (int i = 0; i < GROUPS * ENTRIES; i++) begin
            load_valid = 1'b1;
            load_stage = st;
            load_half  = half;
            load_data  = rnd ? {$urandom(), $urandom()} : base + 64'(i);
            step("load");
        end
        load_valid = 1'b0;
        step("gap");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] w;
        int g_hold;

        // Reset state
        m_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Stream briefly, then reset in the middle of it
        CEN = 1'b0; adv_en = 1'b1; stage_counter = 3'd0;
        repeat (5) step("pre_rst");
        async_reset();
        for (int i = 0; i < 16; i++) step("ident_read");

        // Full load of stage 1, read disabled
        CEN = 1'b1;
        load_burst(3'd1, 1'b0, 64'h100, 1'b0);
        load_burst(3'd1, 1'b1, 64'h200, 1'b0);

        // Stream stage 1 through all groups and back to group 0
        stage_counter = 3'd1; CEN = 1'b0; adv_en = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            step("stream1");
            if (k == 1)   chk("first_q", Q, {64'h100, 64'h200});
            if (k == 5)   chk("entry3_q", Q, {64'h103, 64'h203});
            if (k == 66)  chk("grp1_q", Q, {64'h104, 64'h204});
            if (k == 66)  chk("grp1_idx", 128'(grp_idx), 128'd1);
            if (k == 256) chk("grp3_idx", 128'(grp_idx), 128'd3);
            if (k == 257) chk("grp_wrap", 128'(grp_idx), 128'd0);
        end

        // adv_en dropped at idx 2
        for (int i = 0; i < 8 && (m_pos % ENTRIES) != 2; i++) step("seek_idx2");
        chk("seek_idx2_reached", 128'(m_pos % ENTRIES), 128'd2);
        g_hold = m_grp;
        adv_en = 1'b0; step("adv_drop");
        adv_en = 1'b1; step("adv_resume");
        chk("adv_drop_entry0", Q, m_mem[1][g_hold][0]);
        chk("adv_drop_grp", 128'(grp_idx), 128'(g_hold));

        // Load stage 2 with random data, then switch 1 -> 2
        CEN = 1'b1;
        load_burst(3'd2, 1'b0, 64'd0, 1'b1);
        load_burst(3'd2, 1'b1, 64'd0, 1'b1);
        CEN = 1'b0; adv_en = 1'b1;
        step("before_switch");
        stage_counter = 3'd2;
        step("switch");
        step("after_switch");
        chk("switch_q", Q, m_mem[2][0][0]);
        chk("switch_grp", 128'(grp_idx), 128'd0);

        // Per-stage constants
        for (int s = 0; s < STAGES; s++) begin
            CEN = 1'b1;
            load_stage = 3'(s); const_we = 1'b1;
            const_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("const_wr");
            const_we = 1'b0;
            stage_counter = 3'(s); CEN = 1'b0;
            step("const_rd0");
            step("const_rd1");
            chk("const_value", Q_const, m_const[s]);
        end

        // Out-of-range stage read; Q_const must hold
        w = Q_const;
        stage_counter = 3'd3;
        repeat (4) step("oor_read");
        chk("oor_qconst_hold", Q_const, w);
        chk("oor_q", Q, ID);

        // Load beats to a nonexistent stage, then sweep every table
        CEN = 1'b1;
        load_burst(3'd5, 1'b0, 64'd0, 1'b1);
        for (int s = 0; s < STAGES; s++) begin
            stage_counter = 3'(s); CEN = 1'b0; adv_en = 1'b1;
            repeat (2 + ENTRIES * GROUP_PERIOD * GROUPS) step("sweep_all");
        end

        // Collision: read stage 0 / address 0 while loading its high half
        CEN = 1'b1; adv_en = 1'b0;
        stage_counter = 3'd1; step("coll_prep1");
        stage_counter = 3'd0; step("coll_prep0");
        w = m_mem[0][0][0];
        CEN = 1'b0; load_valid = 1'b1; load_half = 1'b0; load_stage = 3'd0;
        load_data = 64'hABCD;
        step("collide");
        chk("collide_old", Q, w);
        load_valid = 1'b0;
        step("collide_next");
        chk("collide_new_hi", {64'd0, Q[127:64]}, 128'hABCD);
        chk("collide_new_lo", {64'd0, Q[63:0]}, {64'd0, w[63:0]});

        // Randomized traffic with one asynchronous reset in the middle
        for (int c = 0; c < 1500; c++) begin
            CEN        = ($urandom_range(0, 7) == 0);
            adv_en     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) stage_counter = 3'($urandom_range(0, 4));
            load_valid = ($urandom_range(0, 3) == 0);
            load_half  = 1'($urandom_range(0, 1));
            load_stage = 3'($urandom_range(0, 3));
            load_data  = {$urandom(), $urandom()};
            const_we   = ($urandom_range(0, 15) == 0);
            const_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (c == 700) async_reset();
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tw_buf_multistage.md
Name: tw_buf_multistage

Overview:
- Parametrised twiddle-factor buffer for the radix-16 NTT/FFT datapath; successor to the fixed 3-stage, 4-entry twiddle ROM.
- Holds STAGES x GROUPS x ENTRIES twiddle words of P_WIDTH bits, each split into two HALF-wide halves.
- Every stage's table is reloadable at runtime over a HALF-wide horizontal port, not only stage 0.
- Streams one twiddle per cycle to the butterfly, with automatic index/group sequencing and a per-stage constant output.

Parameters:
- P_WIDTH, 128, twiddle word width; HALF = P_WIDTH/2.
- STAGES, 3, number of stages with tables; stage_counter >= STAGES selects identity.
- GROUPS, 4, twiddle groups per stage (power of 2).
- ENTRIES, 4, entries per group (power of 2).
- GROUP_PERIOD, 16, full index sweeps before the group advances (>= 1).
- SC_WIDTH, 3, stage_counter width.
- IDENTITY, {HALF'd1, HALF'd1}, reset content and idle output.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- CEN  in  1  read enable, active-low.
- stage_counter  in  SC_WIDTH  current NTT stage.
- adv_en  in  1  sequencing qualifier (butterfly compute state).
- load_valid  in  1  load beat strobe.
- load_half  in  1  0 = write high half [P_WIDTH-1:HALF], 1 = write low half [HALF-1:0].
- load_stage  in  SC_WIDTH  target stage of the load beat.
- load_data  in  HALF  half-word to write.
- const_we  in  1  write strobe for the constant register of load_stage.
- const_data  in  P_WIDTH  constant value.
- Q  out  P_WIDTH  twiddle output.
- Q_valid  out  1  Q carries a table entry, not identity.
- Q_const  out  P_WIDTH  per-stage constant.
- grp_idx  out  log2(GROUPS)  current group of the active stage (debug/verification).

Behaviour:
- Reset (asynchronous, rst_n low, mid-operation included):
  - All table entries and constant registers load IDENTITY.
  - Q = IDENTITY, Q_const = IDENTITY, Q_valid = 0.
  - All counters and the load pointer clear to 0.
- Load path:
  - The load pointer is a flat address 0..GROUPS*ENTRIES-1; group = ptr / ENTRIES, entry = ptr % ENTRIES.
  - On each cycle with load_valid=1 and load_stage < STAGES, the selected half of mem[load_stage][group][entry] takes load_data, then ptr increments.
  - ptr wraps to 0 after GROUPS*ENTRIES-1.
  - When load_valid=0, ptr resets to 0. A full load is one high-half burst, a gap of at least 1 cycle, then one low-half burst.
  - A beat with load_stage >= STAGES writes nothing but still advances ptr.
  - const_we=1 with load_stage < STAGES writes const_data to const[load_stage].
- Read path (1-cycle latency, registered):
  - CEN=0 and stage_counter < STAGES: Q <= mem[stage_counter][grp][idx], Q_valid <= 1.
  - Otherwise: Q <= IDENTITY, Q_valid <= 0.
  - A load beat and a read to the same address in the same cycle: Q returns the old content; the new value is visible on the next read.
- Sequencer (one set of counters, shared by the active stage):
  - idx: 0..ENTRIES-1. sweep: 0..GROUP_PERIOD-1. grp: 0..GROUPS-1.
  - CEN=0 and adv_en=1: idx increments. When idx wraps, sweep increments. When sweep wraps together with the idx wrap, grp increments; grp wraps to 0 after GROUPS-1.
  - CEN=0 and adv_en=0: idx and sweep clear to 0; grp holds.
  - CEN=1: all counters hold.
  - stage_counter different from its value registered last cycle: idx, sweep and grp clear to 0 in that cycle. This takes priority over advancing, and the read in that cycle uses the pre-clear counters.
  - grp_idx = grp.
- Q_const:
  - CEN=0 and stage_counter < STAGES: Q_const <= const[stage_counter].
  - Otherwise Q_const holds.
  - const_we to the active stage is seen on Q_const one cycle after the write completes.

Test Plan:
- Reset check: assert rst_n low mid-stream with CEN=0 -> Q = IDENTITY, Q_const = IDENTITY, Q_valid=0, grp_idx=0 immediately. Release, then stage 0 with adv_en=1 -> Q = IDENTITY for 16 reads.
- Full load and read-back: load stage 1 high burst of values 0x100+i (i = 0..15), 1-cycle gap, low burst 0x200+i. Then stage_counter=1, CEN=0, adv_en=1 -> Q sequence {0x100,0x200}, {0x101,0x201}, {0x102,0x202}, {0x103,0x203} repeating 16 sweeps, Q_valid=1.
- Group advance and wrap: continue the stream -> grp_idx steps to 1 after 64 cycles, Q = {0x104,0x204}; grp_idx returns to 0 after 256 cycles.
- adv_en drop mid-sweep at idx=2 -> next Q is entry 0 of the same group, grp_idx unchanged. Stage change 1 -> 2 -> grp_idx=0 and Q = stage 2 entry 0 on the second cycle after the change.
- Out-of-range stage: stage_counter=3 with CEN=0 -> Q = IDENTITY, Q_valid=0, Q_const holds. A load beat with load_stage=5 leaves all tables unchanged.
- Collision: read address (stage 0, ptr 0) in the same cycle as a high-half load of 0xABCD to that address -> Q = old value; the next read of that address returns 0xABCD in the high half.
